// File: rtl/ghost_mover_if.sv
// Ghost mover bus: control inputs from the game and chooser, and the
// registered position/motion outputs read by the chooser and renderer.
interface ghost_mover_if #(
    parameter int MAP_W = 18,
    parameter int MAP_H = 5
);
    logic                     enable;
    logic [0:MAP_W*MAP_H-1]   map;
    logic [1:0]               dir_in;
    logic                     caught;
    logic [4:0]               cur_x;
    logic [4:0]               cur_y;
    logic [3:0]               offset;
    logic [1:0]               move_dir;
    logic                     moving;
    logic                     tile_done;

    modport master (
        output enable, map, dir_in, caught,
        input  cur_x, cur_y, offset, move_dir, moving, tile_done
    );

    modport slave (
        input  enable, map, dir_in, caught,
        output cur_x, cur_y, offset, move_dir, moving, tile_done
    );
endinterface

// File: rtl/ghost_mover.sv
// Ghost mover: at each tile centre checks the requested direction against
// the wall map, then walks one tile with a pixel offset, and handles the
// respawn hold after the ghost is caught.
module ghost_mover #(
    parameter int MAP_W         = 18,
    parameter int MAP_H         = 5,
    parameter int TILE_PX       = 16,
    parameter int STEP_DIV      = 1000000,
    parameter int HOME_X        = 8,
    parameter int HOME_Y        = 2,
    parameter int RESPAWN_STEPS = 32
) (
    input  logic          clk,
    input  logic          rst,
    ghost_mover_if.slave  bus
);
    localparam int IW = ($clog2(MAP_W*MAP_H) > 7) ? $clog2(MAP_W*MAP_H) : 7;
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = (RESPAWN_STEPS > 1) ? $clog2(RESPAWN_STEPS) : 1;

    localparam logic [4:0]    LAST_X = 5'(MAP_W - 1);
    localparam logic [4:0]    LAST_Y = 5'(MAP_H - 1);
    localparam logic [4:0]    HOME_XV = 5'(HOME_X);
    localparam logic [4:0]    HOME_YV = 5'(HOME_Y);
    localparam logic [3:0]    OFF_LAST = 4'(TILE_PX - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESPAWN_STEPS - 1);

    typedef enum logic [1:0] {IDLE, DECIDE, MOVE, HOLD} state_t;

    state_t          state;
    logic [4:0]      pos_x;
    logic [4:0]      pos_y;
    logic [3:0]      off;
    logic [1:0]      dir;
    logic            walking;
    logic            done;
    logic [PW-1:0]   prescale;
    logic [HW-1:0]   hold_cnt;

    logic [4:0]      tgt_x;
    logic [4:0]      tgt_y;
    logic            in_bounds;
    logic            legal;
    logic [IW-1:0]   idx;

    function automatic logic [4:0] step_x(input logic [4:0] x, input logic [1:0] d);
        case (d)
            2'b10:   return x - 5'd1;
            2'b11:   return x + 5'd1;
            default: return x;
        endcase
    endfunction

    function automatic logic [4:0] step_y(input logic [4:0] y, input logic [1:0] d);
        case (d)
            2'b00:   return y - 5'd1;
            2'b01:   return y + 5'd1;
            default: return y;
        endcase
    endfunction

    // Legality of the requested step: bounds first, map lookup only when in bounds
    always_comb begin
        tgt_x     = step_x(pos_x, bus.dir_in);
        tgt_y     = step_y(pos_y, bus.dir_in);
        in_bounds = 1'b0;
        idx       = '0;
        legal     = 1'b0;
        case (bus.dir_in)
            2'b00: in_bounds = (pos_y != 5'd0);
            2'b01: in_bounds = (pos_y < LAST_Y);
            2'b10: in_bounds = (pos_x != 5'd0);
            2'b11: in_bounds = (pos_x < LAST_X);
        endcase
        if (in_bounds) begin
            idx   = IW'(tgt_x) + IW'(tgt_y) * IW'(MAP_W);
            legal = !bus.map[idx];
        end
    end

    // Movement FSM with registered outputs; caught overrides enable and normal flow
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pos_x    <= HOME_XV;
            pos_y    <= HOME_YV;
            off      <= 4'd0;
            dir      <= 2'b00;
            walking  <= 1'b0;
            done     <= 1'b0;
            prescale <= '0;
            hold_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (bus.caught) begin
                pos_x    <= HOME_XV;
                pos_y    <= HOME_YV;
                off      <= 4'd0;
                walking  <= 1'b0;
                prescale <= '0;
                hold_cnt <= '0;
                state    <= HOLD;
            end else if (!bus.enable) begin
                if (state == DECIDE) begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: state <= DECIDE;
                    DECIDE: begin
                        if (legal) begin
                            dir      <= bus.dir_in;
                            prescale <= '0;
                            off      <= 4'd0;
                            walking  <= 1'b1;
                            state    <= MOVE;
                        end
                    end
                    MOVE: begin
                        if (prescale == PRE_LAST) begin
                            prescale <= '0;
                            if (off == OFF_LAST) begin
                                pos_x   <= step_x(pos_x, dir);
                                pos_y   <= step_y(pos_y, dir);
                                off     <= 4'd0;
                                done    <= 1'b1;
                                walking <= 1'b0;
                                state   <= DECIDE;
                            end else begin
                                off <= off + 4'd1;
                            end
                        end else begin
                            prescale <= prescale + PW'(1);
                        end
                    end
                    HOLD: begin
                        if (prescale == PRE_LAST) begin
                            prescale <= '0;
                            if (hold_cnt == HOLD_LAST) begin
                                hold_cnt <= '0;
                                state    <= DECIDE;
                            end else begin
                                hold_cnt <= hold_cnt + HW'(1);
                            end
                        end else begin
                            prescale <= prescale + PW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.cur_x     = pos_x;
    assign bus.cur_y     = pos_y;
    assign bus.offset    = off;
    assign bus.move_dir  = dir;
    assign bus.moving    = walking;
    assign bus.tile_done = done;
endmodule
